// File: rtl/buffer_pingpong.sv
// Two-bank ping-pong buffer: one writer fills a FREE bank while up to eight
// independent reader channels drain the FULL bank, each from its own RAM copy.
module buffer_pingpong_ram #(
    parameter int    AW    = 12,
    parameter int    DW    = 512,
    parameter string STYLE = "auto"
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    localparam int DEPTH = 2 ** AW;

    generate
        if (STYLE == "ultra") begin : g_uram
            (* ram_style = "ultra" *) logic [DW-1:0] r_mem [DEPTH];
            always_ff @(posedge clk) begin
                if (i_we) r_mem[i_waddr] <= i_wdata;
                if (i_re) o_rdata <= r_mem[i_raddr];
            end
        end else if (STYLE == "b") begin : g_bram
            (* ram_style = "block" *) logic [DW-1:0] r_mem [DEPTH];
            always_ff @(posedge clk) begin
                if (i_we) r_mem[i_waddr] <= i_wdata;
                if (i_re) o_rdata <= r_mem[i_raddr];
            end
        end else if (STYLE == "d") begin : g_dram
            (* ram_style = "distributed" *) logic [DW-1:0] r_mem [DEPTH];
            always_ff @(posedge clk) begin
                if (i_we) r_mem[i_waddr] <= i_wdata;
                if (i_re) o_rdata <= r_mem[i_raddr];
            end
        end else begin : g_auto
            logic [DW-1:0] r_mem [DEPTH];
            always_ff @(posedge clk) begin
                if (i_we) r_mem[i_waddr] <= i_wdata;
                if (i_re) o_rdata <= r_mem[i_raddr];
            end
        end
    endgenerate
endmodule

module buffer_pingpong #(
    parameter int    BUFFER_ADDR_WIDTH  = 11,
    parameter int    BUFFER_DATA_WIDTH  = 512,
    parameter int    NUM_READ_PORTS     = 2,
    parameter int    RAM_LATENCY        = 2,
    parameter string MEM_POOL_PRIMITIVE = "auto"
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        load_write_addr_valid,
    input  logic [BUFFER_ADDR_WIDTH-1:0]                load_write_addr,
    input  logic [BUFFER_DATA_WIDTH-1:0]                load_write_data,
    input  logic                                        load_done,
    output logic                                        load_bank_ready,
    input  logic [NUM_READ_PORTS-1:0]                   agg_read_addr_valid,
    input  logic [NUM_READ_PORTS*BUFFER_ADDR_WIDTH-1:0] agg_read_addr,
    output logic [NUM_READ_PORTS-1:0]                   agg_read_data_valid,
    output logic [NUM_READ_PORTS*BUFFER_DATA_WIDTH-1:0] agg_read_data,
    input  logic                                        agg_done,
    output logic                                        agg_bank_ready,
    output logic                                        wr_bank,
    output logic                                        rd_bank,
    output logic [1:0]                                  err
);
    localparam int AW = BUFFER_ADDR_WIDTH;
    localparam int DW = BUFFER_DATA_WIDTH;

    logic [1:0] r_bank_full;
    logic       r_wr_bank;
    logic       r_rd_bank;
    logic [1:0] r_err;

    logic w_load_ready;
    logic w_agg_ready;
    logic w_load_done_ok;
    logic w_agg_done_ok;

    assign w_load_ready   = ~r_bank_full[r_wr_bank];
    assign w_agg_ready    = r_bank_full[r_rd_bank];
    assign w_load_done_ok = load_done & w_load_ready;
    assign w_agg_done_ok  = agg_done & w_agg_ready;

    assign load_bank_ready = w_load_ready;
    assign agg_bank_ready  = w_agg_ready;
    assign wr_bank         = r_wr_bank;
    assign rd_bank         = r_rd_bank;
    assign err             = r_err;

    // A FREE write bank and a FULL read bank can never be the same bank, so both
    // handshakes may update r_bank_full in the same cycle without conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank_full <= 2'b00;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_err       <= 2'b00;
        end else begin
            if (w_load_done_ok) begin
                r_bank_full[r_wr_bank] <= 1'b1;
                r_wr_bank              <= ~r_wr_bank;
            end
            if (w_agg_done_ok) begin
                r_bank_full[r_rd_bank] <= 1'b0;
                r_rd_bank              <= ~r_rd_bank;
            end
            if (load_write_addr_valid && !w_load_ready) r_err[0] <= 1'b1;
            if ((|agg_read_addr_valid) && !w_agg_ready) r_err[1] <= 1'b1;
        end
    end

    logic          r_wr_valid;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;
    logic          r_wr_bank_cap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_valid    <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_wr_bank_cap <= 1'b0;
        end else begin
            r_wr_valid <= load_write_addr_valid & w_load_ready;
            if (load_write_addr_valid && w_load_ready) begin
                r_wr_addr     <= load_write_addr;
                r_wr_data     <= load_write_data;
                r_wr_bank_cap <= r_wr_bank;
            end
        end
    end

    genvar gi, gs;
    generate
        for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_ch
            logic                   r_rd_en;
            logic [AW-1:0]          r_rd_addr;
            logic                   r_rd_bank_cap;
            logic [RAM_LATENCY-1:0] r_vpipe;
            logic                   r_out_valid;
            logic [DW-1:0]          r_out_data;
            logic                   w_rd_accept;
            logic [DW-1:0]          w_stage [RAM_LATENCY];

            assign w_rd_accept = agg_read_addr_valid[gi] & w_agg_ready;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_en       <= 1'b0;
                    r_rd_addr     <= '0;
                    r_rd_bank_cap <= 1'b0;
                end else begin
                    r_rd_en <= w_rd_accept;
                    if (w_rd_accept) begin
                        r_rd_addr     <= agg_read_addr[gi*AW +: AW];
                        r_rd_bank_cap <= r_rd_bank;
                    end
                end
            end

            // Each channel owns a full copy of both banks, addressed as {bank, word}.
            buffer_pingpong_ram #(
                .AW    (AW + 1),
                .DW    (DW),
                .STYLE (MEM_POOL_PRIMITIVE)
            ) u_ram (
                .clk     (clk),
                .i_we    (r_wr_valid),
                .i_waddr ({r_wr_bank_cap, r_wr_addr}),
                .i_wdata (r_wr_data),
                .i_re    (r_rd_en),
                .i_raddr ({r_rd_bank_cap, r_rd_addr}),
                .o_rdata (w_stage[0])
            );

            for (gs = 1; gs < RAM_LATENCY; gs++) begin : g_lat
                logic [DW-1:0] r_q;
                always_ff @(posedge clk) r_q <= w_stage[gs-1];
                assign w_stage[gs] = r_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vpipe     <= '0;
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                end else begin
                    r_vpipe[0] <= r_rd_en;
                    for (int s = 1; s < RAM_LATENCY; s++) r_vpipe[s] <= r_vpipe[s-1];
                    r_out_valid <= r_vpipe[RAM_LATENCY-1];
                    r_out_data  <= r_vpipe[RAM_LATENCY-1] ? w_stage[RAM_LATENCY-1] : '0;
                end
            end

            assign agg_read_data_valid[gi]     = r_out_valid;
            assign agg_read_data[gi*DW +: DW]  = r_out_data;
        end
    endgenerate
endmodule

// File: tb/tb_buffer_pingpong.sv
// Directed bench for buffer_pingpong: bank handshakes, read latency, drops and reset.
module tb_buffer_pingpong;
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int NRP = 2;
    localparam int LAT = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                load_write_addr_valid;
    logic [AW-1:0]       load_write_addr;
    logic [DW-1:0]       load_write_data;
    logic                load_done;
    logic                load_bank_ready;
    logic [NRP-1:0]      agg_read_addr_valid;
    logic [NRP*AW-1:0]   agg_read_addr;
    logic [NRP-1:0]      agg_read_data_valid;
    logic [NRP*DW-1:0]   agg_read_data;
    logic                agg_done;
    logic                agg_bank_ready;
    logic                wr_bank;
    logic                rd_bank;
    logic [1:0]          err;

    int checks = 0;
    int errors = 0;

    buffer_pingpong #(
        .BUFFER_ADDR_WIDTH  (AW),
        .BUFFER_DATA_WIDTH  (DW),
        .NUM_READ_PORTS     (NRP),
        .RAM_LATENCY        (LAT),
        .MEM_POOL_PRIMITIVE ("auto")
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .load_write_addr_valid (load_write_addr_valid),
        .load_write_addr       (load_write_addr),
        .load_write_data       (load_write_data),
        .load_done             (load_done),
        .load_bank_ready       (load_bank_ready),
        .agg_read_addr_valid   (agg_read_addr_valid),
        .agg_read_addr         (agg_read_addr),
        .agg_read_data_valid   (agg_read_data_valid),
        .agg_read_data         (agg_read_data),
        .agg_done              (agg_done),
        .agg_bank_ready        (agg_bank_ready),
        .wr_bank               (wr_bank),
        .rd_bank               (rd_bank),
        .err                   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_write_addr_valid = 1'b1;
        load_write_addr       = a;
        load_write_data       = d;
        tick();
        load_write_addr_valid = 1'b0;
        $display("write addr=%0d data=0x%0h bank=%0d", a, d, wr_bank);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_load_ready"}, 64'(load_bank_ready), 64'd1);
        check({tag, "_agg_ready"}, 64'(agg_bank_ready), 64'd0);
        check({tag, "_wr_bank"}, 64'(wr_bank), 64'd0);
        check({tag, "_rd_bank"}, 64'(rd_bank), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_valid"}, 64'(agg_read_data_valid), 64'd0);
        check({tag, "_data"}, 64'(agg_read_data), 64'd0);
    endtask

    initial begin
        rst                   = 1'b1;
        load_write_addr_valid = 1'b0;
        load_write_addr       = '0;
        load_write_data       = '0;
        load_done             = 1'b0;
        agg_read_addr_valid   = '0;
        agg_read_addr         = '0;
        agg_done              = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // agg_done with no FULL bank is ignored
        agg_done = 1'b1;
        tick();
        agg_done = 1'b0;
        check("agg_done_ignored_rd", 64'(rd_bank), 64'd0);
        check("agg_done_ignored_ready", 64'(agg_bank_ready), 64'd0);

        // read before any load_done is dropped
        agg_read_addr_valid = 2'b01;
        tick();
        agg_read_addr_valid = 2'b00;
        check("early_rd_err", 64'(err), 64'd2);
        tick(); tick(); tick();
        check("early_rd_valid", 64'(agg_read_data_valid), 64'd0);
        check("early_rd_agg_ready", 64'(agg_bank_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("err_cleared", 64'(err), 64'd0);

        // fill bank0 and hand it over
        for (int i = 0; i < 8; i++) write_word(AW'(i), DW'(32'hA0 + i));
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check("b0_done_wr_bank", 64'(wr_bank), 64'd1);
        check("b0_done_rd_bank", 64'(rd_bank), 64'd0);
        check("b0_done_agg_ready", 64'(agg_bank_ready), 64'd1);
        check("b0_done_load_ready", 64'(load_bank_ready), 64'd1);

        agg_read_addr_valid = 2'b11;
        agg_read_addr       = {4'd3, 4'd2};
        tick();
        agg_read_addr_valid = 2'b00;
        tick(); tick();
        check("rd_lat_not_early", 64'(agg_read_data_valid), 64'd0);
        tick();
        check("rd_lat_valid", 64'(agg_read_data_valid), 64'd3);
        check("rd_ch0_data", 64'(agg_read_data[0 +: DW]), 64'hA2);
        check("rd_ch1_data", 64'(agg_read_data[DW +: DW]), 64'hA3);
        $display("read ch0=0x%0h ch1=0x%0h", agg_read_data[0 +: DW], agg_read_data[DW +: DW]);
        tick();
        check("rd_idle_valid", 64'(agg_read_data_valid), 64'd0);
        check("rd_idle_data", 64'(agg_read_data), 64'd0);

        // fill bank1, both banks FULL, then an extra write is dropped
        for (int i = 0; i < 8; i++) write_word(AW'(i), DW'(32'hB0 + i));
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check("both_full_load_ready", 64'(load_bank_ready), 64'd0);
        check("both_full_wr_bank", 64'(wr_bank), 64'd0);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check("load_done_ignored", 64'(wr_bank), 64'd0);
        write_word(AW'(0), DW'(32'hDEAD));
        check("drop_wr_err", 64'(err), 64'd1);

        // read in the agg_done cycle hits the old bank, the next read the new one
        agg_done               = 1'b1;
        agg_read_addr_valid    = 2'b01;
        agg_read_addr          = {4'd0, 4'd5};
        tick();
        agg_done = 1'b0;
        check("agg_done_load_ready", 64'(load_bank_ready), 64'd1);
        check("agg_done_rd_bank", 64'(rd_bank), 64'd1);
        check("agg_done_agg_ready", 64'(agg_bank_ready), 64'd1);
        tick();
        agg_read_addr_valid = 2'b00;
        tick(); tick();
        check("swap_old_valid", 64'(agg_read_data_valid), 64'd1);
        check("swap_old_data", 64'(agg_read_data[0 +: DW]), 64'hA5);
        tick();
        check("swap_new_valid", 64'(agg_read_data_valid), 64'd1);
        check("swap_new_data", 64'(agg_read_data[0 +: DW]), 64'hB5);
        tick();
        check("swap_idle_valid", 64'(agg_read_data_valid), 64'd0);
        check("swap_idle_data", 64'(agg_read_data), 64'd0);

        // back-to-back reads on both channels from bank1
        for (int k = 0; k < 12; k++) begin
            if (k < 8) begin
                agg_read_addr_valid = 2'b11;
                agg_read_addr       = {AW'(k), AW'(k)};
            end else begin
                agg_read_addr_valid = 2'b00;
            end
            tick();
            if (k >= 3 && k < 11) begin
                check("burst_valid", 64'(agg_read_data_valid), 64'd3);
                check("burst_ch0", 64'(agg_read_data[0 +: DW]), 64'(32'hB0 + k - 3));
                check("burst_ch1", 64'(agg_read_data[DW +: DW]), 64'(32'hB0 + k - 3));
                $display("burst read %0d ch0=0x%0h ch1=0x%0h", k - 3,
                         agg_read_data[0 +: DW], agg_read_data[DW +: DW]);
            end else begin
                check("burst_gap", 64'(agg_read_data_valid), 64'd0);
            end
        end

        // reset in the middle of a 4-deep read burst
        for (int j = 0; j < 4; j++) begin
            agg_read_addr_valid = 2'b11;
            agg_read_addr       = {AW'(j), AW'(j)};
            tick();
        end
        agg_read_addr_valid = 2'b00;
        check("pre_rst_valid", 64'(agg_read_data_valid), 64'd3);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("post_rst_valid", 64'(agg_read_data_valid), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/buffer_pingpong.md
BUFFER_PINGPONG -- requirements
Module: buffer_pingpong

Interface
REQ-001 SHALL have parameter BUFFER_ADDR_WIDTH, default 11, word address width per bank.
REQ-002 SHALL have parameter BUFFER_DATA_WIDTH, default 512, word width in bits.
REQ-003 SHALL have parameter NUM_READ_PORTS, default 2, number of independent agg read channels (1..8).
REQ-004 SHALL have parameter RAM_LATENCY, default 2, RAM read latency in cycles (1..4).
REQ-005 SHALL have parameter MEM_POOL_PRIMITIVE, default "auto", RAM primitive selection ("ultra","b","d","auto").
REQ-006 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port load_write_addr_valid  in  1  write request strobe.
REQ-009 SHALL have port load_write_addr  in  BUFFER_ADDR_WIDTH  write word address.
REQ-010 SHALL have port load_write_data  in  BUFFER_DATA_WIDTH  write word data.
REQ-011 SHALL have port load_done  in  1  one-cycle pulse: writer has finished filling the current write bank.
REQ-012 SHALL have port load_bank_ready  out  1  high while the current write bank is FREE.
REQ-013 SHALL have port agg_read_addr_valid  in  NUM_READ_PORTS  per-channel read strobe.
REQ-014 SHALL have port agg_read_addr  in  NUM_READ_PORTS*BUFFER_ADDR_WIDTH  per-channel read address; channel i occupies slice [i*AW +: AW].
REQ-015 SHALL have port agg_read_data_valid  out  NUM_READ_PORTS  per-channel read-data strobe.
REQ-016 SHALL have port agg_read_data  out  NUM_READ_PORTS*BUFFER_DATA_WIDTH  per-channel read data, same slicing as REQ-014.
REQ-017 SHALL have port agg_done  in  1  one-cycle pulse: reader has finished with the current read bank.
REQ-018 SHALL have port agg_bank_ready  out  1  high while the current read bank is FULL.
REQ-019 SHALL have port wr_bank  out  1  index of the current write bank.
REQ-020 SHALL have port rd_bank  out  1  index of the current read bank.
REQ-021 SHALL have port err  out  2  sticky flags: bit0 = write dropped, bit1 = read dropped.

Function
REQ-022 SHALL hold two banks (0,1), each of 2**BUFFER_ADDR_WIDTH words, with one RAM copy per read channel; a write goes to every copy of the addressed bank.
REQ-023 SHALL keep a per-bank state: FREE (writable) or FULL (readable); load_done moves wr_bank FREE->FULL and toggles wr_bank; agg_done moves rd_bank FULL->FREE and toggles rd_bank.
REQ-024 SHALL ignore load_done when wr_bank is not FREE, and ignore agg_done when rd_bank is not FULL; no state change in either case.
REQ-025 SHALL apply load_done and agg_done in the same cycle independently, since they address different banks or pass the same bank's state FREE->FULL and FULL->FREE in distinct cycles only.
REQ-026 SHALL register each accepted write (valid, addr, data, bank = wr_bank at capture) for 1 cycle and commit it to RAM on the following edge: 2-cycle write latency.
REQ-027 SHALL drop a write whose strobe arrives while load_bank_ready is low, and set err[0].
REQ-028 SHALL register each accepted read per channel (enable, addr, bank = rd_bank at capture), and return agg_read_data_valid with data exactly RAM_LATENCY+2 cycles after the strobe (4 cycles at default); all channels are fully pipelined, one read per channel per cycle.
REQ-029 SHALL drop a read strobe that arrives while agg_bank_ready is low, assert no data_valid for it, and set err[1].
REQ-030 SHALL drive agg_read_data of a channel to 0 in every cycle its data_valid is low.
REQ-031 SHALL complete in-flight writes and reads to the bank captured at their input stage, even if load_done or agg_done toggles the pointer meanwhile.
REQ-032 SHALL make load_bank_ready, agg_bank_ready, wr_bank and rd_bank reflect the new state on the cycle after the load_done/agg_done edge.

Reset
REQ-033 SHALL, on rst high, immediately set both banks FREE, wr_bank=0, rd_bank=0, load_bank_ready=1, agg_bank_ready=0, err=0, all data_valid=0, all agg_read_data=0, and flush every pipeline stage; RAM contents are not cleared.
REQ-034 SHALL discard reads and writes in flight when reset asserts mid-operation; no data_valid appears after reset deasserts for pre-reset strobes.

Verification
REQ-035 Fill bank0 addr 0..3 with 0xA0..0xA3, pulse load_done, read addr 2 on ch0 and addr 3 on ch1 same cycle -> both data_valid 4 cycles later with 0xA2 / 0xA3; wr_bank=1, rd_bank=0.
REQ-036 Reset, read strobe before any load_done -> no data_valid, err=2'b10, agg_bank_ready=0.
REQ-037 Fill both banks, pulse load_done twice, write once more -> write dropped, err[0]=1, load_bank_ready=0; pulse agg_done -> load_bank_ready=1 next cycle, rd_bank=1.
REQ-038 Issue read on ch0 at addr 5 in the same cycle as agg_done -> data from old bank returned 4 cycles later; next read returns the other bank's word.
REQ-039 Back-to-back reads addr 0..7 on all channels -> eight consecutive data_valid cycles per channel, in order, no gaps.
REQ-040 Assert rst during a 4-deep read burst -> all outputs at reset values the same cycle; no stray data_valid after release.
